// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin frame-granular owner of the RMII TX byte path; optional watchdog under ETH_TX_ARB_WDOG_EN
module eth_tx_arbiter #(
  parameter int          pNum_Req    = 2,
  parameter int          pIfg_Cycles = 48,
  parameter logic [15:0] pMax_Beats  = 16'd1522
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [8*pNum_Req-1:0]   Req_Data,
  input  logic [pNum_Req-1:0]     Req_Valid,
  input  logic [pNum_Req-1:0]     Req_Last,
  output logic [pNum_Req-1:0]     Req_Ready,
  output logic [7:0]              Tx_Data,
  output logic                    Tx_Valid,
  output logic                    Tx_Last,
  input  logic                    Tx_Ready,
  output logic [pNum_Req-1:0]     Grant,
  output logic                    Busy,
  output logic                    Abort
);
  localparam int PW = pNum_Req > 1 ? $clog2(pNum_Req) : 1;
`ifdef ETH_TX_ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_GRANT = 2'd1, ARB_IFG = 2'd2} state_t;
  state_t              state, state_nx;
  logic [pNum_Req-1:0] grant_nx;
  logic [PW-1:0]       idx, idx_nx, ptr, ptr_nx, win, ptr_adv;
  logic [7:0]          ifg, ifg_nx;
  logic [15:0]         beats, beats_nx;
  logic                found, in_grant, wd_hit, xfer, last_xfer;
  assign in_grant  = state == ARB_GRANT;
  assign wd_hit    = WDOG && in_grant && beats == pMax_Beats;
  assign Tx_Data   = (in_grant && !wd_hit) ? Req_Data[int'(idx)*8 +: 8] : 8'd0;
  assign Tx_Valid  = in_grant && (Req_Valid[idx] || wd_hit);
  assign Tx_Last   = in_grant && ((Req_Last[idx] && Req_Valid[idx]) || wd_hit);
  assign Req_Ready = (in_grant && Tx_Ready && !wd_hit) ? Grant : '0;
  assign Busy      = state == ARB_GRANT || state == ARB_IFG;
  assign Abort     = wd_hit;
  assign xfer      = Tx_Valid && Tx_Ready && !wd_hit;
  assign last_xfer = (xfer && Tx_Last) || wd_hit;
  assign ptr_adv   = (idx == PW'(pNum_Req - 1)) ? '0 : idx + PW'(1);
  // round-robin search: first valid requester at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < pNum_Req; i++) begin
      int c;
      c = (int'(ptr) + i) % pNum_Req;
      if (!found && Req_Valid[c]) begin
        found = 1'b1;
        win   = PW'(c);
      end
    end
  end
  // next-state and next register values for the ownership sequence
  always_comb begin
    state_nx = state;
    grant_nx = Grant;
    idx_nx   = idx;
    ptr_nx   = ptr;
    ifg_nx   = ifg;
    beats_nx = beats;
    case (state)
      ARB_IDLE: if (found) begin
        state_nx      = ARB_GRANT;
        grant_nx      = '0;
        grant_nx[win] = 1'b1;
        idx_nx        = win;
        beats_nx      = '0;
      end
      ARB_GRANT: begin
        beats_nx = (xfer && !(&beats)) ? beats + 16'd1 : beats;
        if (last_xfer) begin
          state_nx = ARB_IFG;
          grant_nx = '0;
          ptr_nx   = ptr_adv;
          ifg_nx   = 8'(pIfg_Cycles - 1);
        end
      end
      ARB_IFG: begin
        state_nx = ifg == 8'd0 ? ARB_IDLE : ARB_IFG;
        ifg_nx   = ifg == 8'd0 ? 8'd0 : ifg - 8'd1;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end
  // state and grant registers; reset drops any frame in flight
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ARB_IDLE;
      Grant <= '0;
      idx   <= '0;
      ptr   <= '0;
      ifg   <= '0;
      beats <= '0;
    end else begin
      state <= state_nx;
      Grant <= grant_nx;
      idx   <= idx_nx;
      ptr   <= ptr_nx;
      ifg   <= ifg_nx;
      beats <= beats_nx;
    end
  end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed checks of arbitration, IFG, backpressure, stall and reset for eth_tx_arbiter
module tb_eth_tx_arbiter;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] Req_Data = '0;
  logic [1:0]  Req_Valid = '0;
  logic [1:0]  Req_Last = '0;
  logic [1:0]  Req_Ready;
  logic [7:0]  Tx_Data;
  logic        Tx_Valid;
  logic        Tx_Last;
  logic        Tx_Ready = 1'b1;
  logic [1:0]  Grant;
  logic        Busy;
  logic        Abort;
  int checks = 0;
  int failures = 0;

  eth_tx_arbiter #(.pNum_Req(2), .pIfg_Cycles(48), .pMax_Beats(16'd1522)) dut (
    .Clk(Clk), .Rst(Rst), .Req_Data(Req_Data), .Req_Valid(Req_Valid), .Req_Last(Req_Last),
    .Req_Ready(Req_Ready), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid), .Tx_Last(Tx_Last),
    .Tx_Ready(Tx_Ready), .Grant(Grant), .Busy(Busy), .Abort(Abort)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame(input int k, input int len, input bit bp, input int stall_at);
    int n = 0;
    int st = 0;
    logic [7:0] b;
    bit rdy, vld, lst;
    for (int cyc = 0; cyc < len * 3 + 20 && n < len; cyc++) begin
      rdy = bp ? (cyc % 2 == 0) : 1'b1;
      vld = !(n == stall_at && st < 10);
      if (!vld) st++;
      b = 8'(n * 7 + k * 64 + 1);
      lst = (n == len - 1);
      Tx_Ready = rdy;
      Req_Valid[k] = vld;
      Req_Last[k] = lst;
      Req_Data[k*8 +: 8] = b;
      #1;
      chk("tx_data", 32'(Tx_Data), 32'(b));
      chk("tx_valid", 32'(Tx_Valid), 32'(vld));
      chk("tx_last", 32'(Tx_Last), 32'(lst & vld));
      chk("req_ready", 32'(Req_Ready), 32'(rdy) << k);
      chk("grant_hold", 32'(Grant), 32'(1) << k);
      if (rdy && vld) n++;
      step();
    end
    chk("frame_len", 32'(n), 32'(len));
    Req_Valid[k] = 1'b0;
    Req_Last[k] = 1'b0;
    Tx_Ready = 1'b1;
  endtask

  task automatic ifg_check();
    for (int j = 0; j < 48; j++) begin
      #1;
      chk("ifg_busy", 32'(Busy), 32'd1);
      chk("ifg_grant", 32'(Grant), 32'd0);
      chk("ifg_txv", 32'(Tx_Valid), 32'd0);
      step();
    end
    #1;
    chk("idle_busy", 32'(Busy), 32'd0);
  endtask

  initial begin
    repeat (3) step();
    #1;
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_abort", 32'(Abort), 32'd0);
    chk("rst_txv", 32'(Tx_Valid), 32'd0);
    chk("rst_txl", 32'(Tx_Last), 32'd0);
    chk("rst_ready", 32'(Req_Ready), 32'd0);
    chk("rst_txd", 32'(Tx_Data), 32'd0);
    Rst = 1'b0;
    step();
    Req_Valid = 2'b01;
    Req_Data[7:0] = 8'h01;
    #1;
    chk("idle_no_grant", 32'(Grant), 32'd0);
    chk("idle_no_ready", 32'(Req_Ready), 32'd0);
    step();
    chk("single_grant", 32'(Grant), 32'd1);
    chk("single_busy", 32'(Busy), 32'd1);
    frame(0, 60, 1'b0, -1);
    ifg_check();
    step();
    chk("single_stay_idle", 32'(Grant), 32'd0);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    Req_Valid = 2'b11;
    step();
    chk("cont_req0_first", 32'(Grant), 32'd1);
    frame(0, 8, 1'b0, -1);
    ifg_check();
    step();
    chk("cont_req1_second", 32'(Grant), 32'd2);
    frame(1, 8, 1'b0, -1);
    ifg_check();
    Req_Valid = 2'b11;
    step();
    chk("cont_ptr0_req0", 32'(Grant), 32'd1);
    frame(0, 8, 1'b0, -1);
    ifg_check();
    Req_Valid = 2'b11;
    step();
    chk("cont_ptr1_req1", 32'(Grant), 32'd2);
    frame(1, 8, 1'b0, -1);
    ifg_check();
    Req_Valid = 2'b11;
    step();
    chk("bp_grant", 32'(Grant), 32'd1);
    frame(0, 64, 1'b1, -1);
    ifg_check();
    step();
    chk("bp_next_req1", 32'(Grant), 32'd2);
    frame(1, 4, 1'b0, -1);
    ifg_check();
    Req_Valid = 2'b11;
    step();
    chk("stall_grant", 32'(Grant), 32'd1);
    frame(0, 30, 1'b0, 20);
    ifg_check();
    Req_Valid = 2'b11;
    step();
    chk("post_stall_req1", 32'(Grant), 32'd2);
    for (int i = 0; i < 29; i++) begin
      Req_Data[15:8] = 8'(i);
      step();
    end
    #1;
    chk("pre_rst_txv", 32'(Tx_Valid), 32'd1);
    Rst = 1'b1;
    step();
    chk("midrst_grant", 32'(Grant), 32'd0);
    chk("midrst_txv", 32'(Tx_Valid), 32'd0);
    chk("midrst_txl", 32'(Tx_Last), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    Rst = 1'b0;
    #1;
    chk("midrst_idle_grant", 32'(Grant), 32'd0);
    step();
    chk("midrst_ptr0_req0", 32'(Grant), 32'd1);
    chk("abort_low", 32'(Abort), 32'd0);
    Req_Valid = 2'b00;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single RMII transmit MAC byte path between N frame sources. Examples: host TX FIFO, ARP responder, loopback of received frames.
- Uses round-robin arbitration at frame granularity. A grant is held until the frame's last byte, then an inter-frame gap is enforced before the next grant.
- Sits between the requester byte streams and the TX MAC's byte interface.
- The MAC handles preamble/SFD/FCS generation; this block sequences frame ownership only.

Parameters:
- pNum_Req, 2, number of requesters N (1..8).
- pIfg_Cycles, 48, inter-frame gap in Clk cycles after the last byte is accepted (96 bit times at 2 bits/clk); legal range 1..255.
- pMax_Beats, 16'd1522, byte limit per frame; used only when the watchdog is compiled in.

Ports:
- Clk  in  1  system clock (50 MHz RMII reference).
- Rst  in  1  synchronous, active-high reset.
- Req_Data  in  8*N  byte from each requester; requester k occupies bits [8k+7:8k].
- Req_Valid  in  N  byte valid per requester; a rising Req_Valid while not granted is a frame request.
- Req_Last  in  N  marks the final byte of a frame; qualified by Req_Valid.
- Req_Ready  out  N  per-requester accept; only the granted bit may be 1.
- Tx_Data  out  8  byte to MAC.
- Tx_Valid  out  1  byte valid to MAC.
- Tx_Last  out  1  last byte of frame to MAC.
- Tx_Ready  in  1  MAC accepts the byte this cycle.
- Grant  out  N  one-hot registered grant; all zero when no owner.
- Busy  out  1  high in GRANT or IFG.
- Abort  out  1  one-cycle pulse on watchdog abort (feature only).

Behaviour:
- Reset values: Grant=0, Busy=0, Abort=0, Tx_Valid=0, Tx_Last=0, Req_Ready=0, Tx_Data=0. Round-robin pointer=0, IFG counter=0, beat counter=0, state=ARB_IDLE.
- State machine (2-bit): ARB_IDLE(0), ARB_GRANT(1), ARB_IFG(2); the unused encoding returns to ARB_IDLE.
- ARB_IDLE:
  - Search Req_Valid from the pointer index upward, wrapping modulo N; the first set bit k wins.
  - Next cycle: Grant=onehot(k), state=ARB_GRANT.
  - Latency from Req_Valid to Grant is 1 cycle. No Req_Valid means stay in ARB_IDLE.
- ARB_GRANT, combinational outputs from the registered grant k:
  - Tx_Data=Req_Data[k], Tx_Valid=Req_Valid[k], Tx_Last=Req_Last[k]&Req_Valid[k].
  - Req_Ready[k]=Tx_Ready; all other Req_Ready bits are 0.
- Transfer occurs when Tx_Valid & Tx_Ready. If Req_Valid[k] drops mid-frame, Tx_Valid=0 and the grant is held; there is no timeout unless the watchdog is compiled in.
- A transfer with Tx_Last causes, on the next cycle:
  - Grant=0, pointer=(k+1) mod N, IFG counter=pIfg_Cycles-1, state=ARB_IFG.
- ARB_IFG:
  - Req_Ready=0 and Tx_Valid=0. The counter decrements each cycle; at 0, state=ARB_IDLE.
  - Exactly pIfg_Cycles cycles elapse with no owner before a new grant can be computed in ARB_IDLE.
- Requests arriving during GRANT or IFG are not lost: they are sampled when ARB_IDLE is re-entered, since requesters hold Req_Valid.
- Simultaneous requests: the winner is the lowest index at or after the pointer. Example with N=2, pointer=1, both requesting: requester 1 wins.
- N=1: the pointer stays 0, and IFG is still enforced.
- When not in ARB_GRANT: Tx_Data=0, Tx_Valid=0, Tx_Last=0.
- Busy=1 exactly when state is ARB_GRANT or ARB_IFG.
- Rst asserted mid-frame: all registers return to reset values on that edge, with no Tx_Last emitted. The MAC observes Tx_Valid drop and discards the frame.
- Beat counter is 16 bits. It clears on grant and increments per transfer; it saturates at 16'hFFFF.

Optional Feature:
- Macro ETH_TX_ARB_WDOG_EN.
- Defined:
  - If the beat counter reaches pMax_Beats in ARB_GRANT without a Tx_Last transfer, force Tx_Last=1 and Tx_Valid=1 for one cycle, with Tx_Data=0.
  - Pulse Abort for that cycle, drive Req_Ready[k]=0 in that cycle, and enter ARB_IFG with the pointer advanced.
  - The requester must drop the rest of its frame.
- Undefined: the watchdog is absent, Abort is tied 0, and the beat counter may be optimised away.

Test Plan:
- Single request: Req_Valid[0] held, 60-byte frame, Tx_Ready=1 -> Grant=01 one cycle later; Tx_Data mirrors 60 bytes; Tx_Last on byte 60; Grant=00 for 48 cycles; Busy low afterwards.
- Contention: both requesters valid from reset -> req0 frame first, then 48 IFG cycles, then req1 frame; a repeat with both valid serves req0 again. The pointer alternates 0→1→0.
- Backpressure: Tx_Ready toggles 1,0,1,0 during a 64-byte frame -> exactly 64 transfers, no byte duplicated/lost, Req_Ready[0] equals Tx_Ready, Req_Ready[1]=0 throughout.
- Mid-frame stall: Req_Valid[0] low for 10 cycles at byte 20 while req1 is valid -> Grant stays 01, Tx_Valid=0 during the stall, req1 not granted until after frame end plus 48 cycles.
- Reset mid-frame: assert Rst at byte 30 -> next cycle Grant=0, Tx_Valid=0, Busy=0; after release, req1 valid is granted with pointer 0 semantics (req0 valid wins if both valid).
- Watchdog (ETH_TX_ARB_WDOG_EN, pMax_Beats=100): frame with no Req_Last -> at beat 100 Tx_Last=1, Abort pulses 1 cycle, 48 IFG cycles, then the other requester is granted.
